uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data bus, downstream of the core data port, decoded in parallel with data RAM.
- Stores to its address window push bytes into a TX FIFO; a bit-level FSM serialises them 8N1 on `tx`.
- Loads return status and config on `rdata`; the top level ORs `rdata` into the core's read-data path when `sel`=1.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; decode on daddr[31:4]==BASE_ADDR[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, 2..64.
- DEFAULT_DIV, 16'd434, reset value of BAUDDIV in clocks per bit.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- daddr  in  32  data address from core.
- ddata_w  in  32  store data from core.
- MemWrite  in  1  store strobe, sampled on CLK rising edge.
- MemRead  in  1  load strobe.
- sel  out  1  combinational; 1 when daddr is in the window.
- rdata  out  32  combinational read data; 0 unless sel & MemRead.
- tx  out  1  serial line, idle high.
- irq  out  1  TX-done interrupt (see Optional Feature).

Behaviour:
- Register map (offset = daddr[3:2]):
  - 0 TXDATA: write pushes ddata_w[7:0]; reads 0.
  - 1 STATUS (read):
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[14:8] FIFO count
    - others 0
  - 1 STATUS (write): writing 1 to bit3 clears overflow; other bits ignored.
  - 2 BAUDDIV: R/W in [15:0]; upper bits read 0.
  - 3 IRQCTL: only when the macro is defined.
- Writes take effect only when sel & MemWrite at a rising edge. MemRead has no side effects.
- Reset values:
  - tx=1, irq=0, FSM IDLE.
  - FIFO empty: pointers 0, count 0.
  - overflow=0, BAUDDIV=DEFAULT_DIV.
  - Shift register and bit counters 0.
- Effective bit period P = max(BAUDDIV,1) clocks. BAUDDIV is sampled when entering START and held for the whole frame.
- FSM:
  - IDLE: tx=1. If FIFO non-empty at an edge: pop head into shift reg, go START.
  - START: tx=0 for P clocks, then DATA.
  - DATA: tx=shift[0]. Every P clocks shift right; after 8 bits go STOP.
  - STOP: tx=1 for P clocks. At the end, if FIFO non-empty, pop and go START directly (no idle gap); else IDLE.
- tx is driven from a register; no combinational glitches.
- Latency: TXDATA write at edge N with FSM IDLE and FIFO empty. Byte enters FIFO at N, popped at N+1, tx low from N+1. Full frame is 10·P clocks.
- FIFO behaviour:
  - Push when full: byte dropped, overflow set, FIFO unchanged.
  - Simultaneous push and pop at the same edge: both occur, count unchanged. This holds when full: the pop frees a slot, so no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- A BAUDDIV write mid-frame does not disturb the current frame; the new value applies from the next START.
- RESET mid-frame: tx returns to 1 immediately (async) and FIFO contents are discarded.
- Out-of-window access: no state change; sel=0, rdata=0.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- When defined:
  - IRQCTL bit0 = irq_enable (R/W, reset 0).
  - IRQCTL bit1 = done flag. Set when the FSM returns to IDLE with the FIFO empty; writing 1 to bit1 clears it.
  - irq is registered: irq = irq_enable & done.
  - If a set and a clear of done coincide, set wins.
- When undefined: offset 3 reads 0, writes are ignored, irq is tied 0.

Test Plan:
- Reset with RESET=1 for 2 cycles -> tx=1, irq=0. STATUS read = 0x0000_0004 (empty). BAUDDIV read = 434.
- BAUDDIV=4, write TXDATA 0x55 -> from next cycle, tx per 4 clocks: 0,1,0,1,0,1,0,1,0,1. busy=1 throughout; IDLE after 40 clocks; STATUS back to 0x4.
- BAUDDIV=2, write 0xA1, 0x0F back-to-back -> two frames, 20 clocks each, contiguous. Second start bit follows first stop bit with no idle cycle.
- FIFO_DEPTH=8, BAUDDIV=100, 10 writes in 10 consecutive cycles -> first pops at once, 8 buffered, 10th dropped. STATUS shows full=1, overflow=1, count=8. Write 0x8 to STATUS -> overflow=0.
- Assert RESET during DATA bit 3 with 3 bytes queued -> tx=1 that cycle, count=0, no further frames after reset release.
- With UART_TX_IRQ_EN: IRQCTL=1, send 1 byte at BAUDDIV=2 -> irq rises 1 clock after FSM reaches IDLE. Write 0x3 to IRQCTL -> irq=0 next cycle.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO on the core data bus.
// Optional IRQCTL register and TX-done interrupt enabled by defining UART_TX_IRQ_EN.
`timescale 1ns/1ps
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  // state   | meaning
  // S_IDLE  | line idle high, waiting for a queued byte
  // S_START | start bit (low) for one bit period
  // S_DATA  | eight data bits, LSB first
  // S_STOP  | stop bit (high); chains straight into S_START if more bytes queued
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]    off;
  logic          wr_en, rd_en, push;
  logic          unused_bits;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    count7;
  logic          full, empty, pop, push_ok;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q, div_d, eff_div;

  state_t        state_q, state_d;
  logic [15:0]   per_q, per_d, cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy, term;

  logic [31:0]   status, irqctl, rdata_mux;

  assign sel         = (daddr[31:4] == BASE_ADDR[31:4]);
  assign off         = daddr[3:2];
  assign wr_en       = sel & MemWrite;
  assign rd_en       = sel & MemRead;
  assign push        = wr_en && (off == 2'd0);
  assign unused_bits = ^{daddr[1:0], ddata_w[31:16]};

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push & (~full | pop);
  assign count7  = 7'(count_q);
  assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;
  assign term    = (cnt_q == 16'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = ddata_w[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A pop at the same edge frees a slot, so a push into a full FIFO is only lost without one.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && (off == 2'd1) && ddata_w[3]) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
    div_d = (wr_en && (off == 2'd2)) ? ddata_w[15:0] : div_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (term) state_d = S_DATA;
      S_DATA:  if (term && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP: begin
        if (term) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bit period is latched on every pop so a BAUDDIV write cannot stretch a frame in flight.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    per_d   = per_q;
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
      per_d   = eff_div;
      cnt_d   = eff_div - 16'd1;
      bit_d   = 3'd0;
    end else if (state_q != S_IDLE) begin
      if (term) begin
        cnt_d = per_q - 16'd1;
        if (state_q == S_DATA) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      per_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      per_q   <= per_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;

  // Completion is applied after the software clear so a coincident set wins.
  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    if (wr_en && (off == 2'd3)) begin
      irq_en_d = ddata_w[0];
      if (ddata_w[1]) done_d = 1'b0;
    end
    if ((state_q == S_STOP) && (state_d == S_IDLE)) done_d = 1'b1;
    irq_d = irq_en_q & done_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  assign irq    = irq_q;
  assign irqctl = {30'b0, done_q, irq_en_q};
`else
  assign irq    = 1'b0;
  assign irqctl = 32'b0;
`endif

  assign status = {17'b0, count7, 4'b0, ovf_q, empty, full, busy};

  always_comb begin
    case (off)
      2'd1:    rdata_mux = status;
      2'd2:    rdata_mux = {16'b0, div_q};
      2'd3:    rdata_mux = irqctl;
      default: rdata_mux = 32'b0;
    endcase
    rdata = rd_en ? rdata_mux : 32'b0;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vector table, directed frame sequences,
// and randomized multi-byte traffic checked against a frame-timing reference model.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam int LOGN = 32768;
  localparam logic [31:0] A_TX = 32'h1000, A_ST = 32'h1004, A_DIV = 32'h1008, A_IRQ = 32'h100C;
`ifdef UART_TX_IRQ_EN
  localparam logic [31:0] IRQ_RB = 32'h1;
`else
  localparam logic [31:0] IRQ_RB = 32'h0;
`endif

  logic        CLK, RESET, MemWrite, MemRead, sel, tx, irq;
  logic [31:0] daddr, ddata_w, rdata;

  uart_tx_mmio dut (
    .CLK(CLK), .RESET(RESET), .daddr(daddr), .ddata_w(ddata_w),
    .MemWrite(MemWrite), .MemRead(MemRead), .sel(sel), .rdata(rdata),
    .tx(tx), .irq(irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int   cyc = 0;
  int   irq_hi = 0;
  logic tx_log  [LOGN];
  logic irq_log [LOGN];

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (cyc < LOGN) begin
      tx_log[cyc]  = tx;
      irq_log[cyc] = irq;
    end
    if (irq) irq_hi++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    daddr = a; ddata_w = d; MemWrite = 1'b1;
    @(negedge CLK);
    MemWrite = 1'b0;
  endtask

  task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
    daddr = a; MemRead = 1'b1;
    #1;
    d = rdata;
    MemRead = 1'b0;
  endtask

  // Line waveform of one 8N1 frame, one sample per clock: start, data LSB first, stop.
  function automatic logic [63:0] frame_exp(input logic [7:0] b, input int p);
    logic [63:0] v;
    int bi;
    v = '0;
    for (int k = 0; k < 10 * p; k++) begin
      bi = k / p;
      v[k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
    end
    return v;
  endfunction

  logic [7:0] fr_byte [16];
  int         fr_per  [16];

  task automatic check_stream(input int s0, input int n, input string tag);
    int s;
    logic [63:0] e, a;
    #2;
    s = s0;
    for (int j = 0; j < n; j++) begin
      e = frame_exp(fr_byte[j], fr_per[j]);
      a = '0;
      for (int k = 0; k < 10 * fr_per[j]; k++) a[k] = tx_log[s + k];
      check($sformatf("%s frame%0d", tag, j), a, e);
      s += 10 * fr_per[j];
    end
    check($sformatf("%s idle_after", tag), 64'(tx_log[s]), 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [31:0] d;
    int n, w, e, s, p, zc, busy_cnt, old_div, new_div, nb, irq_base;

    RESET = 1'b1; daddr = '0; ddata_w = '0; MemWrite = 1'b0; MemRead = 1'b0;

    vt[0]  = '{A_ST,          1'b0, 1'b1, 32'h0,          1'b1, 32'h4};
    vt[1]  = '{A_DIV,         1'b0, 1'b1, 32'h0,          1'b1, 32'd434};
    vt[2]  = '{A_TX,          1'b0, 1'b1, 32'h0,          1'b1, 32'h0};
    vt[3]  = '{A_IRQ,         1'b0, 1'b1, 32'h0,          1'b1, 32'h0};
    vt[4]  = '{A_DIV,         1'b1, 1'b0, 32'hABCD_0007,  1'b1, 32'h0};
    vt[5]  = '{A_DIV,         1'b0, 1'b1, 32'h0,          1'b1, 32'h7};
    vt[6]  = '{32'h2008,      1'b1, 1'b0, 32'h99,         1'b0, 32'h0};
    vt[7]  = '{A_DIV,         1'b0, 1'b1, 32'h0,          1'b1, 32'h7};
    vt[8]  = '{32'h2004,      1'b0, 1'b1, 32'h0,          1'b0, 32'h0};
    vt[9]  = '{A_ST,          1'b0, 1'b0, 32'h0,          1'b1, 32'h0};
    vt[10] = '{A_ST,          1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 32'h0};
    vt[11] = '{A_ST,          1'b0, 1'b1, 32'h0,          1'b1, 32'h4};
    vt[12] = '{A_IRQ,         1'b1, 1'b0, 32'h3,          1'b1, 32'h0};
    vt[13] = '{A_IRQ,         1'b0, 1'b1, 32'h0,          1'b1, IRQ_RB};
    vt[14] = '{A_IRQ,         1'b1, 1'b0, 32'h0,          1'b1, 32'h0};
    vt[15] = '{32'h0000_0FF8, 1'b1, 1'b0, 32'h5,          1'b0, 32'h0};
    vt[16] = '{A_DIV,         1'b0, 1'b1, 32'h0,          1'b1, 32'h7};
    vt[17] = '{A_DIV,         1'b1, 1'b0, 32'h0,          1'b1, 32'h0};
    vt[18] = '{A_DIV,         1'b0, 1'b1, 32'h0,          1'b1, 32'h0};

    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("reset tx", 64'(tx), 64'd1);
    check("reset irq", 64'(irq), 64'd0);

    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      daddr = vt[i].addr;
      if (vt[i].wr) begin
        ddata_w = vt[i].wdata; MemWrite = 1'b1;
        #1;
        check($sformatf("vec%0d sel", i), 64'(sel), 64'(vt[i].exp_sel));
        @(negedge CLK);
        MemWrite = 1'b0;
      end else begin
        MemRead = vt[i].rd;
        #1;
        check($sformatf("vec%0d sel", i), 64'(sel), 64'(vt[i].exp_sel));
        check($sformatf("vec%0d rdata", i), 64'(rdata), 64'(vt[i].exp_rdata));
        MemRead = 1'b0;
      end
    end

    // Single 0x55 frame at P=4, busy for exactly 40 clocks.
    @(negedge CLK);
    do_write(A_DIV, 32'd4);
    do_write(A_TX, 32'h55);
    n = cyc;
    busy_cnt = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge CLK);
      rd_now(A_ST, d);
      if (d[0]) busy_cnt++;
    end
    check("p4 busy_cycles", 64'(busy_cnt), 64'd40);
    check("p4 status_end", 64'(d), 64'h4);
    fr_byte[0] = 8'h55; fr_per[0] = 4;
    check_stream(n + 1, 1, "p4");

    // Back-to-back frames at P=2 must be contiguous.
    @(negedge CLK);
    do_write(A_DIV, 32'd2);
    do_write(A_TX, 32'hA1);
    n = cyc;
    do_write(A_TX, 32'h0F);
    repeat (42) @(negedge CLK);
    fr_byte[0] = 8'hA1; fr_per[0] = 2;
    fr_byte[1] = 8'h0F; fr_per[1] = 2;
    check_stream(n + 1, 2, "p2pair");
    rd_now(A_ST, d);
    check("p2pair status_end", 64'(d), 64'h4);

    // Overflow: 10 pushes, one popped immediately, 8 buffered, last dropped.
    @(negedge CLK);
    do_write(A_DIV, 32'd100);
    for (int i = 0; i < 10; i++) do_write(A_TX, 32'(i + 8'h30));
    rd_now(A_ST, d);
    check("ovf status", 64'(d), 64'h80B);
    @(negedge CLK);
    do_write(A_ST, 32'h7);
    rd_now(A_ST, d);
    check("ovf keep", 64'(d), 64'h80B);
    @(negedge CLK);
    do_write(A_ST, 32'h8);
    rd_now(A_ST, d);
    check("ovf clear", 64'(d), 64'h803);

    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    rd_now(A_DIV, d);
    check("reset2 div", 64'(d), 64'd434);
    @(negedge CLK);
    rd_now(A_ST, d);
    check("reset2 status", 64'(d), 64'h4);

    // Reset during data bit 3 of the first of four queued bytes.
    @(negedge CLK);
    do_write(A_DIV, 32'd4);
    do_write(A_TX, 32'h00);
    do_write(A_TX, 32'h11);
    do_write(A_TX, 32'h22);
    do_write(A_TX, 32'h33);
    repeat (15) @(negedge CLK);
    rd_now(A_ST, d);
    check("midrst status_before", 64'(d), 64'h301);
    check("midrst tx_before", 64'(tx), 64'd0);
    RESET = 1'b1;
    #1;
    check("midrst tx_async", 64'(tx), 64'd1);
    rd_now(A_ST, d);
    check("midrst status_in_reset", 64'(d), 64'h4);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    zc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!tx) zc++;
    end
    check("midrst no_frames", 64'(zc), 64'd0);
    rd_now(A_ST, d);
    check("midrst status_after", 64'(d), 64'h4);

`ifdef UART_TX_IRQ_EN
    @(negedge CLK);
    do_write(A_IRQ, 32'h1);
    do_write(A_DIV, 32'd2);
    do_write(A_TX, 32'h5A);
    n = cyc;
    repeat (23) @(negedge CLK);
    #2;
    check("irq before", 64'(irq_log[n + 21]), 64'd0);
    check("irq rise", 64'(irq_log[n + 22]), 64'd1);
    rd_now(A_IRQ, d);
    check("irqctl done", 64'(d), 64'h3);
    @(negedge CLK);
    do_write(A_IRQ, 32'h3);
    @(negedge CLK);
    #1;
    check("irq cleared", 64'(irq), 64'd0);
    rd_now(A_IRQ, d);
    check("irqctl after_clear", 64'(d), 64'h1);
    @(negedge CLK);
    do_write(A_IRQ, 32'h0);
`endif

    // Random traffic with a BAUDDIV change landing somewhere after the pushes.
    irq_base = irq_hi;
    for (int it = 0; it < 12; it++) begin
      @(negedge CLK);
      old_div = $urandom_range(0, 5);
      new_div = $urandom_range(0, 5);
      nb = $urandom_range(1, 8);
      do_write(A_DIV, 32'(old_div));
      for (int j = 0; j < nb; j++) begin
        fr_byte[j] = 8'($urandom);
        do_write(A_TX, {24'h0, fr_byte[j]});
        if (j == 0) n = cyc;
      end
      repeat ($urandom_range(0, 20)) @(negedge CLK);
      do_write(A_DIV, 32'(new_div));
      w = cyc;
      s = n + 1;
      for (int j = 0; j < nb; j++) begin
        p = (w < s) ? new_div : old_div;
        if (p == 0) p = 1;
        fr_per[j] = p;
        s += 10 * p;
      end
      e = s;
      while (cyc < e + 2) @(negedge CLK);
      check_stream(n + 1, nb, $sformatf("rand%0d", it));
      rd_now(A_ST, d);
      check($sformatf("rand%0d status_end", it), 64'(d), 64'h4);
    end
    check("irq quiet", 64'(irq_hi - irq_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
